// File: rtl/opll_bus_pkg.sv
// Shared types and default timing constants for the OPLL host-side write port.
package opll_bus_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_A_SETUP,
        ST_A_STROBE,
        ST_A_HOLD,
        ST_A_WAIT,
        ST_D_SETUP,
        ST_D_STROBE,
        ST_D_HOLD,
        ST_D_WAIT
    } state_e;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } req_t;

    localparam int unsigned REQ_W          = 16;
    localparam int unsigned DEF_WR_PULSE   = 2;
    localparam int unsigned DEF_ADDR_WAIT  = 12;
    localparam int unsigned DEF_DATA_WAIT  = 84;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/opll_bus_writer_if.sv
// Request stream plus OPLL parallel write port; master = host side, slave = bus writer.
interface opll_bus_writer_if #(
    parameter int unsigned FIFO_DEPTH = opll_bus_pkg::DEF_FIFO_DEPTH
) ();
    localparam int unsigned LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic               req_valid;
    logic [7:0]         req_addr;
    logic [7:0]         req_data;
    logic               req_ready;
    logic [7:0]         din;
    logic               a0;
    logic               cs_n;
    logic               wr_n;
    logic               busy;
    logic [LEVEL_W-1:0] fifo_level;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, din, a0, cs_n, wr_n, busy, fifo_level
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, din, a0, cs_n, wr_n, busy, fifo_level
    );
endinterface

// File: rtl/opll_wr_fifo.sv
// Synchronous request FIFO with occupancy count; full/empty are registered flags.
module opll_wr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_c,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned LEVEL_W = PTR_W + 1;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;
    logic [LEVEL_W-1:0] level_d;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head_c  = mem[rd_ptr];

    always_comb begin
        level_d = level;
        case ({do_push, do_pop})
            2'b10:   level_d = level + LEVEL_W'(1);
            2'b01:   level_d = level - LEVEL_W'(1);
            default: level_d = level;
        endcase
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level_d;
            full  <= (level_d == LEVEL_W'(DEPTH));
            empty <= (level_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/opll_bus_writer.sv
// Turns queued {addr,data} requests into OPLL address/data write cycles with
// the chip's mandatory post-write wait times.
module opll_bus_writer
    import opll_bus_pkg::*;
#(
    parameter int unsigned WR_PULSE   = DEF_WR_PULSE,
    parameter int unsigned ADDR_WAIT  = DEF_ADDR_WAIT,
    parameter int unsigned DATA_WAIT  = DEF_DATA_WAIT,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input logic               clk,
    input logic               rst_n,
    opll_bus_writer_if.slave  bus
);
    localparam int unsigned CNT_MAX = max3(WR_PULSE, ADDR_WAIT, DATA_WAIT);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    req_t               in_req;
    req_t               head_c;
    logic               push_c;
    logic               pop_c;
    logic               start_c;
    logic               fifo_full;
    logic               fifo_empty;
    logic [LEVEL_W-1:0] level;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         data_q, data_d;
    logic [7:0]         din_q, din_d;
    logic               a0_q, a0_d;
    logic               cs_n_q, cs_n_d;
    logic               wr_n_q, wr_n_d;

    assign in_req = req_t'{addr: bus.req_addr, data: bus.req_data};
    assign push_c = bus.req_valid && !fifo_full;

    opll_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push_c),
        .wdata  (in_req),
        .pop    (pop_c),
        .head_c (head_c),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (level)
    );

    // Next-state and next-output logic; din doubles as the address holding register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        din_d   = din_q;
        a0_d    = a0_q;
        cs_n_d  = cs_n_q;
        wr_n_d  = wr_n_q;
        pop_c   = 1'b0;
        start_c = 1'b0;

        case (state_q)
            ST_IDLE: start_c = !fifo_empty;
            ST_A_SETUP: begin
                state_d = ST_A_STROBE;
                wr_n_d  = 1'b0;
                cnt_d   = CNT_W'(WR_PULSE);
            end
            ST_A_STROBE: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_A_HOLD;
                    wr_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_A_HOLD: begin
                state_d = ST_A_WAIT;
                cs_n_d  = 1'b1;
                cnt_d   = CNT_W'(ADDR_WAIT);
            end
            ST_A_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_D_SETUP;
                    cs_n_d  = 1'b0;
                    a0_d    = 1'b1;
                    din_d   = data_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_D_SETUP: begin
                state_d = ST_D_STROBE;
                wr_n_d  = 1'b0;
                cnt_d   = CNT_W'(WR_PULSE);
            end
            ST_D_STROBE: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_D_HOLD;
                    wr_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_D_HOLD: begin
                state_d = ST_D_WAIT;
                cs_n_d  = 1'b1;
                cnt_d   = CNT_W'(DATA_WAIT);
            end
            ST_D_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    start_c = !fifo_empty;
                    if (fifo_empty) state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Shared entry into A_SETUP from IDLE or straight from the end of D_WAIT.
        if (start_c) begin
            pop_c   = 1'b1;
            data_d  = head_c.data;
            din_d   = head_c.addr;
            a0_d    = 1'b0;
            cs_n_d  = 1'b0;
            wr_n_d  = 1'b1;
            state_d = ST_A_SETUP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            din_q   <= '0;
            a0_q    <= 1'b0;
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            din_q   <= din_d;
            a0_q    <= a0_d;
            cs_n_q  <= cs_n_d;
            wr_n_q  <= wr_n_d;
        end
    end

    assign bus.din        = din_q;
    assign bus.a0         = a0_q;
    assign bus.cs_n       = cs_n_q;
    assign bus.wr_n       = wr_n_q;
    assign bus.req_ready  = !fifo_full;
    assign bus.busy       = (state_q != ST_IDLE) || !fifo_empty;
    assign bus.fifo_level = level;

endmodule

// File: tb/tb_opll_bus_writer.sv
// Bench for opll_bus_writer: timeline reference model for the default instance,
// literal waveform table for a minimum-timing instance.
module tb_opll_bus_writer;
    localparam int unsigned W     = 2;
    localparam int unsigned A     = 12;
    localparam int unsigned D     = 84;
    localparam int unsigned DEPTH = 4;
    localparam int          LA    = int'(2 + W + A);
    localparam int          P     = LA + int'(2 + W + D);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    opll_bus_writer_if #(.FIFO_DEPTH(DEPTH)) bus_a ();
    opll_bus_writer_if #(.FIFO_DEPTH(DEPTH)) bus_b ();

    opll_bus_writer #(.WR_PULSE(W), .ADDR_WAIT(A), .DATA_WAIT(D), .FIFO_DEPTH(DEPTH))
        u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

    opll_bus_writer #(.WR_PULSE(1), .ADDR_WAIT(1), .DATA_WAIT(1), .FIFO_DEPTH(DEPTH))
        u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
    endtask

    // Expected bus levels at offset u into one phase (setup, strobe, hold, wait).
    function automatic logic exp_cs_at(input int u);
        return (u < int'(2 + W)) ? 1'b0 : 1'b1;
    endfunction
    function automatic logic exp_wr_at(input int u);
        return (u >= 1 && u < int'(1 + W)) ? 1'b0 : 1'b1;
    endfunction

    // Reference model: queue of accepted requests plus position inside the current write.
    logic [15:0] mq [$];
    logic [15:0] m_cur    = '0;
    bit          m_active = 1'b0;
    int          m_t      = 0;
    logic [7:0]  e_din    = '0;
    logic        e_a0     = 1'b0;
    logic        e_cs     = 1'b1;
    logic        e_wr     = 1'b1;
    logic        e_busy   = 1'b0;
    logic        e_ready  = 1'b1;
    int          e_level  = 0;

    initial begin : model
        int sz;
        bit acc;
        bit pop_now;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_active = 1'b0;
                m_t      = 0;
                e_din    = '0;
                e_a0     = 1'b0;
            end else begin
                sz      = mq.size();
                acc     = bus_a.req_valid && (sz < int'(DEPTH));
                pop_now = (sz > 0) && (!m_active || m_t == P - 1);
                if (m_active && m_t != P - 1) begin
                    m_t++;
                end else if (pop_now) begin
                    m_cur    = mq.pop_front();
                    m_active = 1'b1;
                    m_t      = 0;
                end else begin
                    m_active = 1'b0;
                end
                if (acc) mq.push_back({bus_a.req_addr, bus_a.req_data});
            end
            if (m_active) begin
                if (m_t < LA) begin
                    e_a0  = 1'b0;
                    e_din = m_cur[15:8];
                    e_cs  = exp_cs_at(m_t);
                    e_wr  = exp_wr_at(m_t);
                end else begin
                    e_a0  = 1'b1;
                    e_din = m_cur[7:0];
                    e_cs  = exp_cs_at(m_t - LA);
                    e_wr  = exp_wr_at(m_t - LA);
                end
            end else begin
                e_cs = 1'b1;
                e_wr = 1'b1;
            end
            e_level = mq.size();
            e_ready = (mq.size() < int'(DEPTH));
            e_busy  = m_active || (mq.size() > 0);
        end
    end

    int         wr_low_cnt = 0;
    int         cs_low_cnt = 0;
    int         strobe_cnt = 0;
    bit         saw_full   = 1'b0;
    int         setup_cyc [$];
    logic       prev_wr    = 1'b1;
    logic       prev_cs    = 1'b1;
    logic       prev_a0    = 1'b0;
    logic [7:0] prev_din   = '0;

    // Per-cycle comparison against the model plus bus-protocol monitor.
    initial begin : compare
        forever begin
            @(negedge clk);
            check("cs_n",       32'(bus_a.cs_n),       32'(e_cs));
            check("wr_n",       32'(bus_a.wr_n),       32'(e_wr));
            check("din",        32'(bus_a.din),        32'(e_din));
            check("a0",         32'(bus_a.a0),         32'(e_a0));
            check("busy",       32'(bus_a.busy),       32'(e_busy));
            check("req_ready",  32'(bus_a.req_ready),  32'(e_ready));
            check("fifo_level", 32'(bus_a.fifo_level), 32'(e_level));
            if (!bus_a.wr_n) begin
                wr_low_cnt++;
                check("wr_without_cs", 32'(bus_a.cs_n), 32'(0));
                if (!prev_wr) begin
                    check("din_stable_in_strobe", 32'(bus_a.din), 32'(prev_din));
                    check("a0_stable_in_strobe",  32'(bus_a.a0),  32'(prev_a0));
                end else begin
                    strobe_cnt++;
                end
            end
            if (!bus_a.cs_n) cs_low_cnt++;
            if (!bus_a.cs_n && prev_cs && !bus_a.a0) setup_cyc.push_back(cyc);
            if (!bus_a.req_ready) saw_full = 1'b1;
            prev_wr  = bus_a.wr_n;
            prev_cs  = bus_a.cs_n;
            prev_a0  = bus_a.a0;
            prev_din = bus_a.din;
        end
    end

    // Call at a negedge; returns at the negedge after the accepting edge.
    task automatic send_a(input logic [7:0] ad, input logic [7:0] da);
        int n = 0;
        bus_a.req_valid = 1'b1;
        bus_a.req_addr  = ad;
        bus_a.req_data  = da;
        while (!bus_a.req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!bus_a.req_ready) timeout("send_a");
        else @(negedge clk);
        bus_a.req_valid = 1'b0;
    endtask

    task automatic wait_idle_a(input string name);
        int n = 0;
        while (bus_a.busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (bus_a.busy) timeout(name);
    endtask

    initial begin : stim
        int         n;
        int         w0;
        int         c0;
        int         s0;
        logic [8:0] tab_cs;
        logic [8:0] tab_wr;
        logic [8:0] tab_a0;
        logic [8:0] tab_busy;

        bus_a.req_valid = 1'b0;
        bus_a.req_addr  = '0;
        bus_a.req_data  = '0;
        bus_b.req_valid = 1'b0;
        bus_b.req_addr  = '0;
        bus_b.req_data  = '0;

        repeat (3) @(negedge clk);
        check("rst_cs_n",   32'(bus_a.cs_n),       32'(1));
        check("rst_wr_n",   32'(bus_a.wr_n),       32'(1));
        check("rst_din",    32'(bus_a.din),        32'(0));
        check("rst_a0",     32'(bus_a.a0),         32'(0));
        check("rst_busy",   32'(bus_a.busy),       32'(0));
        check("rst_ready",  32'(bus_a.req_ready),  32'(1));
        check("rst_level",  32'(bus_a.fifo_level), 32'(0));
        #3 rst_n = 1'b1;
        @(negedge clk);

        // Single write with hand-computed timing.
        send_a(8'h10, 8'h5A);
        w0 = wr_low_cnt;
        c0 = cs_low_cnt;
        @(negedge clk);
        check("t1_setup_cs_n", 32'(bus_a.cs_n), 32'(0));
        check("t1_setup_a0",   32'(bus_a.a0),   32'(0));
        check("t1_setup_din",  32'(bus_a.din),  32'(8'h10));
        check("t1_setup_wr_n", 32'(bus_a.wr_n), 32'(1));
        @(negedge clk);
        check("t1_wr_fall", 32'(bus_a.wr_n), 32'(0));
        n = 1;
        while (bus_a.busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("t1_busy_cycles", 32'(n), 32'(104));
        check("t1_wr_low_total", 32'(wr_low_cnt - w0), 32'(4));
        check("t1_cs_low_total", 32'(cs_low_cnt - c0), 32'(8));
        check("t1_last_din", 32'(bus_a.din), 32'(8'h5A));

        // Six consecutive requests: FIFO fills, back-pressure, 104-cycle period.
        setup_cyc.delete();
        saw_full = 1'b0;
        for (int i = 0; i < 6; i++) send_a(8'(32'h20 + i), 8'($urandom));
        wait_idle_a("t2_drain");
        check("t2_backpressure", 32'(saw_full), 32'(1));
        check("t2_writes", 32'(setup_cyc.size()), 32'(6));
        for (int i = 1; i < setup_cyc.size(); i++)
            check("t2_period", 32'(setup_cyc[i] - setup_cyc[i-1]), 32'(104));
        check("t2_level_drained", 32'(bus_a.fifo_level), 32'(0));

        // Reset pulse during the data strobe.
        send_a(8'h30, 8'hA1);
        send_a(8'h31, 8'hA2);
        send_a(8'h32, 8'hA3);
        n = 0;
        while (!(bus_a.a0 && !bus_a.wr_n) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!(bus_a.a0 && !bus_a.wr_n)) timeout("t3_d_strobe");
        #2 rst_n = 1'b0;
        #1;
        check("t3_async_wr_n",  32'(bus_a.wr_n),       32'(1));
        check("t3_async_cs_n",  32'(bus_a.cs_n),       32'(1));
        check("t3_async_level", 32'(bus_a.fifo_level), 32'(0));
        check("t3_async_busy",  32'(bus_a.busy),       32'(0));
        @(negedge clk);
        @(negedge clk);
        #3 rst_n = 1'b1;
        s0 = strobe_cnt;
        repeat (300) @(negedge clk);
        check("t3_no_strobes", 32'(strobe_cnt - s0), 32'(0));

        // Minimum timing instance: one write is 8 cycles, every strobe 1 cycle.
        tab_cs   = 9'b110001000;
        tab_wr   = 9'b111011101;
        tab_a0   = 9'b111110000;
        tab_busy = 9'b011111111;
        bus_b.req_valid = 1'b1;
        bus_b.req_addr  = 8'hC3;
        bus_b.req_data  = 8'h3C;
        @(negedge clk);
        bus_b.req_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check("b_cs_n", 32'(bus_b.cs_n), 32'(tab_cs[k]));
            check("b_wr_n", 32'(bus_b.wr_n), 32'(tab_wr[k]));
            check("b_a0",   32'(bus_b.a0),   32'(tab_a0[k]));
            check("b_busy", 32'(bus_b.busy), 32'(tab_busy[k]));
            check("b_din",  32'(bus_b.din),  (k < 4) ? 32'(8'hC3) : 32'(8'h3C));
        end

        // Random request streams with idle gaps and short bursts.
        for (int it = 0; it < 25; it++) begin
            repeat ($urandom_range(0, 120)) @(negedge clk);
            for (int j = 0; j < int'($urandom_range(1, 3)); j++)
                send_a(8'($urandom), 8'($urandom));
        end
        wait_idle_a("rand_drain");
        check("rand_level_drained", 32'(bus_a.fifo_level), 32'(0));
        check("rand_ready_final",   32'(bus_a.req_ready),  32'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
